// File: rtl/traffic_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_ctrl
//   Two-road traffic-light sequencer with a pedestrian walk phase.
//   An external down-counting timer is started by t_start with t_length
//   ticks and reports t_done / t_flicker back to this controller.
//   Green and walk lamps blink while the timer is in its final ticks.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   t_done     in   timer expired (level; stale in the first cycle of a state)
//   t_flicker  in   timer in its final ticks (level; stale in the first cycle)
//   ped_req    in   pedestrian request, sampled every cycle
//   t_start    out  one-cycle pulse in the first cycle of every state but INIT
//   t_length   out  timer length for the current state
//   ns_light   out  north-south lamp, one-hot {red,yellow,green}
//   ew_light   out  east-west lamp, one-hot {red,yellow,green}
//   walk       out  pedestrian walk lamp
//
// States
//   state      | meaning
//   -----------+------------------------------------------------------------
//   INIT       | after reset, both red, leaves unconditionally on next edge
//   NS_GREEN   | north-south green, east-west red
//   NS_YELLOW  | north-south yellow, east-west red
//   RED_1      | all red, then walk or east-west green
//   EW_GREEN   | east-west green, north-south red
//   EW_YELLOW  | east-west yellow, north-south red
//   RED_2      | all red, then walk or north-south green
//   WALK       | all red, walk lamp on, then the green recorded in r_dir
// ---------------------------------------------------------------------------
module traffic_ctrl #(
  parameter int G_LEN = 20,
  parameter int Y_LEN = 5,
  parameter int R_LEN = 2,
  parameter int W_LEN = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       t_done,
  input  logic       t_flicker,
  input  logic       ped_req,
  output logic       t_start,
  output logic [4:0] t_length,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk
);

  // The timer length port is 5 bits wide, so every phase length must fit.
  if (G_LEN < 1 || G_LEN > 31) begin : g_chk_g_len
    $error("traffic_ctrl: G_LEN must be in 1..31");
  end
  if (Y_LEN < 1 || Y_LEN > 31) begin : g_chk_y_len
    $error("traffic_ctrl: Y_LEN must be in 1..31");
  end
  if (R_LEN < 1 || R_LEN > 31) begin : g_chk_r_len
    $error("traffic_ctrl: R_LEN must be in 1..31");
  end
  if (W_LEN < 1 || W_LEN > 31) begin : g_chk_w_len
    $error("traffic_ctrl: W_LEN must be in 1..31");
  end

  localparam logic [4:0] LEN_G = 5'(G_LEN);
  localparam logic [4:0] LEN_Y = 5'(Y_LEN);
  localparam logic [4:0] LEN_R = 5'(R_LEN);
  localparam logic [4:0] LEN_W = 5'(W_LEN);

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [2:0] {
    INIT,
    NS_GREEN,
    NS_YELLOW,
    RED_1,
    EW_GREEN,
    EW_YELLOW,
    RED_2,
    WALK
  } state_t;

  state_t     r_state;
  logic       r_first;
  logic       r_blink;
  logic       r_ped_pend;
  logic       r_dir;
  logic [4:0] r_len;
  logic [2:0] r_ns;
  logic [2:0] r_ew;
  logic       r_walk;

  state_t     w_next;
  logic       w_adv;
  logic       w_ped;
  logic       w_blink_en;
  logic       w_dark;

  // Per-state decode, applied to the next state so the lamp and length
  // registers already hold the right values in the first cycle of a state.
  function automatic logic [4:0] f_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   f_len = LEN_G;
      NS_YELLOW, EW_YELLOW: f_len = LEN_Y;
      RED_1, RED_2:         f_len = LEN_R;
      WALK:                 f_len = LEN_W;
      default:              f_len = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] f_ns(input state_t s);
    case (s)
      NS_GREEN:  f_ns = LIGHT_GRN;
      NS_YELLOW: f_ns = LIGHT_YEL;
      default:   f_ns = LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] f_ew(input state_t s);
    case (s)
      EW_GREEN:  f_ew = LIGHT_GRN;
      EW_YELLOW: f_ew = LIGHT_YEL;
      default:   f_ew = LIGHT_RED;
    endcase
  endfunction

  // A request arriving in the last cycle of an all-red phase still counts.
  assign w_ped = r_ped_pend | ped_req;

  // Timer feedback is stale in the first cycle of a state, so only a
  // non-first t_done may end a timed state.
  assign w_adv = (r_state == INIT) || (!r_first && t_done);

  assign w_blink_en = !r_first && t_flicker &&
                      (r_state == NS_GREEN || r_state == EW_GREEN || r_state == WALK);

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:      w_next = NS_GREEN;
      NS_GREEN:  w_next = NS_YELLOW;
      NS_YELLOW: w_next = RED_1;
      RED_1:     w_next = w_ped ? WALK : EW_GREEN;
      EW_GREEN:  w_next = EW_YELLOW;
      EW_YELLOW: w_next = RED_2;
      RED_2:     w_next = w_ped ? WALK : NS_GREEN;
      WALK:      w_next = (r_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
      default:   w_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= INIT;
      r_first    <= 1'b0;
      r_blink    <= 1'b0;
      r_ped_pend <= 1'b0;
      r_dir      <= DIR_NS;
      r_len      <= 5'd0;
      r_ns       <= LIGHT_RED;
      r_ew       <= LIGHT_RED;
      r_walk     <= 1'b0;
    end else begin
      r_first <= 1'b0;

      if (ped_req && r_state != WALK) begin
        r_ped_pend <= 1'b1;
      end

      if (w_blink_en) begin
        r_blink <= ~r_blink;
      end

      // State entry overrides the per-cycle updates above.
      if (w_adv) begin
        r_state <= w_next;
        r_first <= 1'b1;
        r_blink <= 1'b0;
        r_len   <= f_len(w_next);
        r_ns    <= f_ns(w_next);
        r_ew    <= f_ew(w_next);
        r_walk  <= (w_next == WALK);
        if (w_next == WALK) begin
          r_ped_pend <= 1'b0;
          r_dir      <= (r_state == RED_1) ? DIR_EW : DIR_NS;
        end
      end
    end
  end

  // Blink only ever masks the green bit and the walk lamp; r_blink can only
  // be set in green or WALK and is cleared on every entry.
  assign w_dark = t_flicker & r_blink;

  assign t_start  = r_first;
  assign t_length = r_len;
  assign ns_light = {r_ns[2:1], r_ns[0] & ~w_dark};
  assign ew_light = {r_ew[2:1], r_ew[0] & ~w_dark};
  assign walk     = r_walk & ~w_dark;

endmodule

// File: tb/tb_traffic_ctrl.sv
module tb_traffic_ctrl;

  localparam int G = 10;
  localparam int Y = 3;
  localparam int R = 2;
  localparam int W = 8;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] DRK = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       t_done;
  logic       t_flicker;
  logic       ped_req = 1'b0;
  logic       t_start;
  logic [4:0] t_length;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  bit         stuck = 1'b0;

  always #5 clk = ~clk;

  traffic_ctrl #(.G_LEN(G), .Y_LEN(Y), .R_LEN(R), .W_LEN(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .t_done   (t_done),
    .t_flicker(t_flicker),
    .ped_req  (ped_req),
    .t_start  (t_start),
    .t_length (t_length),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk)
  );

  // Companion timer: loads length-1 on start, counts to zero, done at zero,
  // flicker in its last six ticks. A stub mode pins t_done at 1.
  logic [4:0] tm_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tm_cnt <= 5'd0;
    else if (t_start)         tm_cnt <= t_length - 5'd1;
    else if (tm_cnt != 5'd0)  tm_cnt <= tm_cnt - 5'd1;
  end
  assign t_done    = stuck ? 1'b1 : (tm_cnt == 5'd0);
  assign t_flicker = stuck ? 1'b0 : (tm_cnt < 5'd6);

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  // Reference model: a phase plus the 1-based cycle index inside it.
  typedef enum int {P_INIT, P_NSG, P_NSY, P_R1, P_EWG, P_EWY, P_R2, P_WALK} phase_t;
  phase_t m_ph = P_INIT;
  phase_t m_after = P_NSG;
  int     m_k = 1;
  bit     m_pend = 1'b0;

  function automatic int ph_len(input phase_t p);
    case (p)
      P_NSG, P_EWG: return G;
      P_NSY, P_EWY: return Y;
      P_R1, P_R2:   return R;
      P_WALK:       return W;
      default:      return 0;
    endcase
  endfunction

  function automatic int ph_dur(input phase_t p);
    if (p == P_INIT) return 1;
    if (stuck) return 2;
    return ph_len(p) + 1;
  endfunction

  // Blinking lamps: lit until the flicker window, then lit/dark alternately
  // starting lit. The flicker window is the last six cycles of the phase.
  function automatic bit lit(input int k, input int len);
    int fs;
    if (stuck || k == 1) return 1'b1;
    fs = len - 4;
    if (fs < 2) fs = 2;
    if (k < fs) return 1'b1;
    return ((k - fs) % 2) == 0;
  endfunction

  function automatic logic [12:0] expect_now();
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       ts;
    bit         lt;
    int         len;
    ns  = RED;
    ew  = RED;
    wk  = 1'b0;
    len = ph_len(m_ph);
    lt  = lit(m_k, len);
    ts  = (m_k == 1) && (m_ph != P_INIT);
    case (m_ph)
      P_NSG:  ns = lt ? GRN : DRK;
      P_NSY:  ns = YEL;
      P_EWG:  ew = lt ? GRN : DRK;
      P_EWY:  ew = YEL;
      P_WALK: wk = lt;
      default: ;
    endcase
    return {ts, 5'(len), ns, ew, wk};
  endfunction

  task automatic model_advance(input bit req);
    bit     pend_now;
    phase_t nx;
    pend_now = m_pend | (req && m_ph != P_WALK);
    if (m_k < ph_dur(m_ph)) begin
      m_k++;
      m_pend = pend_now;
    end else begin
      nx = P_INIT;
      case (m_ph)
        P_INIT: nx = P_NSG;
        P_NSG:  nx = P_NSY;
        P_NSY:  nx = P_R1;
        P_R1:   begin
                  nx = pend_now ? P_WALK : P_EWG;
                  if (pend_now) m_after = P_EWG;
                end
        P_EWG:  nx = P_EWY;
        P_EWY:  nx = P_R2;
        P_R2:   begin
                  nx = pend_now ? P_WALK : P_NSG;
                  if (pend_now) m_after = P_NSG;
                end
        P_WALK: nx = m_after;
        default: nx = P_INIT;
      endcase
      if (nx == P_WALK) pend_now = 1'b0;
      m_pend = pend_now;
      m_ph   = nx;
      m_k    = 1;
    end
  endtask

  // One clock cycle of stimulus: drive inputs just after the edge, queue the
  // expected outputs for this cycle, then move the model to the next cycle.
  task automatic step(input bit req, input bit rst);
    @(posedge clk);
    #1;
    reset   = rst;
    ped_req = req;
    if (rst) begin
      m_ph    = P_INIT;
      m_k     = 1;
      m_pend  = 1'b0;
      m_after = P_NSG;
      exp_q.push_back({1'b0, 5'd0, RED, RED, 1'b0});
    end else begin
      exp_q.push_back(expect_now());
      model_advance(req);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] a;
    logic        ns_act;
    logic        ew_act;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {t_start, t_length, ns_light, ew_light, walk};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual start/len/ns/ew/walk=%b/%0d/%b/%b/%b required=%b/%0d/%b/%b/%b",
                 $time, a[12], a[11:7], a[6:4], a[3:1], a[0], e[12], e[11:7], e[6:4], e[3:1], e[0]);
      end
      ns_act = |ns_light[1:0];
      ew_act = |ew_light[1:0];
      checks++;
      if ((ns_act && ew_act) || (walk && (ns_act || ew_act))) begin
        failures++;
        $display("FAIL conflict t=%0t actual ns=%b ew=%b walk=%b required no simultaneous go",
                 $time, ns_light, ew_light, walk);
      end
    end
  end

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    // Nominal sequence with no pedestrian.
    hold_reset(3);
    for (int c = 0; c < 40; c++) step(1'b0, 1'b0);

    // One-cycle request at cycle 3.
    hold_reset(2);
    for (int c = 0; c < 45; c++) step(c == 3, 1'b0);

    // Request held from cycle 19 through the end of the resulting walk.
    hold_reset(2);
    for (int c = 0; c < 110; c++) step(c >= 19 && c <= 45, 1'b0);

    // Reset pulse in the middle of NS_GREEN.
    hold_reset(2);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int c = 0; c < 25; c++) step(1'b0, 1'b0);

    // Randomised requests with occasional resets.
    hold_reset(2);
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end

    // Stub timer with t_done stuck high.
    hold_reset(1);
    stuck = 1'b1;
    hold_reset(1);
    for (int c = 0; c < 60; c++) step($urandom_range(0, 3) == 0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameters SHALL be:
  G_LEN, default 20, green time in ticks.
  Y_LEN, default 5, yellow time in ticks.
  R_LEN, default 2, all-red time in ticks.
  W_LEN, default 15, walk time in ticks.
  Each parameter SHALL be in 1..31; an elaboration-time check SHALL fail on any other value.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
  clk  in  1  clock; all state updates on the rising edge.
  reset  in  1  asynchronous, active-high reset.
  t_done  in  1  timer expired; level, valid only as defined in REQ-007.
  t_flicker  in  1  timer is in its final ticks; level.
  ped_req  in  1  pedestrian request; level, sampled every cycle.
  t_start  out  1  one-cycle timer start pulse.
  t_length  out  5  timer length for the current state.
  ns_light  out  3  north-south light, one-hot {red,yellow,green}.
  ew_light  out  3  east-west light, one-hot {red,yellow,green}.
  walk  out  1  pedestrian walk lamp.

Function
REQ-003 The FSM SHALL have exactly these states: INIT, NS_GREEN, NS_YELLOW, RED_1, EW_GREEN, EW_YELLOW, RED_2, WALK.
REQ-004 Non-pedestrian sequence: NS_GREEN -> NS_YELLOW -> RED_1 -> EW_GREEN -> EW_YELLOW -> RED_2 -> NS_GREEN.
REQ-005 INIT SHALL go unconditionally to NS_GREEN on the first clock edge after reset deasserts.
REQ-006 On every state entry except INIT, t_start SHALL be 1 for exactly the first cycle in that state, and 0 otherwise.
  - Implementation: a registered "first" flag, set on every transition and cleared one cycle later.
REQ-007 t_done and t_flicker SHALL be ignored in the first cycle of a state, because the timer still reflects the previous run.
REQ-008 A timed state SHALL advance at the edge ending the first non-first cycle in which t_done=1.
REQ-009 Latency: with a conforming timer, a state of length L SHALL last exactly L+1 cycles.
REQ-010 t_length SHALL equal the state's parameter for the whole state:
  - NS_GREEN, EW_GREEN: G_LEN.
  - NS_YELLOW, EW_YELLOW: Y_LEN.
  - RED_1, RED_2: R_LEN.
  - WALK: W_LEN.
  - INIT: 0.
REQ-011 Light outputs by state:
  - NS_GREEN: ns=green, ew=red.
  - NS_YELLOW: ns=yellow, ew=red.
  - EW_GREEN: ns=red, ew=green.
  - EW_YELLOW: ns=red, ew=yellow.
  - INIT, RED_1, RED_2, WALK: both red.
REQ-012 walk SHALL be 1 only in WALK.
REQ-013 Blink: a 1-bit blink register SHALL clear on every state entry.
  - It SHALL toggle each cycle in which the state is a green state or WALK, it is not the first cycle, and t_flicker=1.
REQ-014 In a green state, the green bit SHALL read 0 when t_flicker=1 and blink=1, and 1 otherwise. The first flicker cycle is therefore lit, the next dark, and so on.
REQ-015 In WALK, walk SHALL follow the same blink rule as REQ-014.
REQ-016 Yellow and red outputs SHALL never blink.
REQ-017 Pedestrian latch: ped_pend SHALL set in any cycle with ped_req=1 while the state is not WALK, and SHALL clear on entry to WALK.
  - ped_req during WALK SHALL be ignored.
REQ-018 Walk routing:
  - When RED_1 or RED_2 completes with ped_pend=1, the next state SHALL be WALK instead of the next green.
  - A direction register SHALL record which green follows WALK: EW_GREEN after RED_1, NS_GREEN after RED_2.
  - ped_req in the final cycle of RED_x (same cycle as t_done) SHALL count as pending for that transition.
REQ-019 No state SHALL ever drive green or yellow on both roads at once. No green or yellow SHALL be active in WALK.
REQ-020 All outputs SHALL be decoded from registered state only; no input-to-output combinational path SHALL exist except t_flicker to green/walk (REQ-014/015).

Reset
REQ-021 While reset=1, outputs SHALL be: state=INIT, t_start=0, t_length=0, ns_light=100, ew_light=100, walk=0.
  - Internal registers SHALL reset to: first=0, blink=0, ped_pend=0, direction=NS.
REQ-022 Reset asserted mid-state SHALL force INIT asynchronously, discarding the pending request and blink.
  - After reset deasserts, the sequence SHALL restart per REQ-005.

Verification
Benches SHALL connect the companion timer and use G_LEN=10, Y_LEN=3, R_LEN=2, W_LEN=8 unless stated otherwise. Cycle 0 is the first cycle after reset deasserts.
REQ-023 Nominal sequence, ped_req=0:
  - NS_GREEN cycles 1-11, t_start=1 in cycle 1 only.
  - NS_YELLOW 12-15, RED_1 16-18, EW_GREEN 19-29.
  - t_length=10, 3, 2, 10 in those states.
REQ-024 Flicker in NS_GREEN:
  - ns green bit SHALL read 1,1,1,1,1 in cycles 1-5.
  - It SHALL then read 1,0,1,0,1,0 in cycles 6-11.
REQ-025 Pedestrian request: ped_req pulsed 1 cycle at cycle 3:
  - WALK SHALL occupy cycles 19-27 with both roads red.
  - EW_GREEN SHALL start at cycle 28.
  - walk SHALL blink during cycles 22-27.
REQ-026 ped_req held high from cycle 19 through the end of the walk:
  - Only one WALK SHALL occur per request window.
  - A request present after WALK entry SHALL be ignored.
  - No WALK SHALL follow RED_2 unless ped_req is reasserted outside WALK.
REQ-027 Reset pulse at cycle 8 (mid NS_GREEN):
  - Outputs SHALL immediately show both red, t_start=0.
  - Release SHALL give INIT, then NS_GREEN with t_start=1 on the next cycle.
REQ-028 Stub timer with t_done stuck at 1:
  - Each state SHALL last exactly 2 cycles, because t_done is ignored in the first cycle.
  - t_start SHALL pulse once per state.
